// File: rtl/calc_sequencer.sv
// Switch-driven 4-bit calculator controller: debounces ENTER, sequences A/B/OP entry,
// launches the external ALU with a done timeout, and multiplexes the 4-digit display.
module calc_sequencer #(
  parameter int DB_CYC   = 16,
  parameter int SCAN_DIV = 1000,
  parameter int TO_CYC   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic [1:0] sw_op,
  input  logic       sw_enter,
  input  logic       sw_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_go,
  input  logic [7:0] alu_y,
  input  logic       alu_done,
  output logic [3:0] state_led,
  output logic       err,
  output logic [3:0] dig_en,
  output logic [3:0] dig_val
);

  localparam int DBW = $clog2(DB_CYC + 1);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int TOW = $clog2(TO_CYC);

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SHOW   = 3'd4
  } state_t;

  logic           sync1_r, sync2_r, db_level_r, enter_p_r;
  logic [DBW-1:0] db_cnt_r;
  state_t         state_r, state_nx_s;
  logic [3:0]     a_r, b_r, a_nx_s, b_nx_s;
  logic [1:0]     op_r, op_nx_s;
  logic [7:0]     y_r, y_nx_s;
  logic           err_r, err_nx_s, go_r, go_nx_s, timeout_s;
  logic [3:0]     led_r, led_nx_s;
  logic [TOW-1:0] to_cnt_r;
  logic [SCW-1:0] pre_r, pre_nx_s;
  logic [1:0]     idx_r, idx_nx_s;
  logic [3:0]     dig_en_r, dig_val_r, dig_val_nx_s;
  logic           wrap_s;

  // ENTER synchronizer, debounce counter and rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      db_cnt_r   <= {DBW{1'b0}};
      enter_p_r  <= 1'b0;
    end else begin
      sync1_r <= sw_enter;
      sync2_r <= sync1_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r  <= {DBW{1'b0}};
        enter_p_r <= 1'b0;
      end else if (db_cnt_r == DBW'(DB_CYC - 1)) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= {DBW{1'b0}};
        enter_p_r  <= sync2_r;
      end else begin
        db_cnt_r  <= db_cnt_r + {{(DBW-1){1'b0}}, 1'b1};
        enter_p_r <= 1'b0;
      end
    end
  end

  assign timeout_s = (to_cnt_r == TOW'(TO_CYC - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_GET_A;
    else        state_r <= state_nx_s;
  end

  // Next-state logic; clear overrides everything including a coincident ENTER
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_GET_A:  state_nx_s = enter_p_r ? ST_GET_B  : ST_GET_A;
      ST_GET_B:  state_nx_s = enter_p_r ? ST_GET_OP : ST_GET_B;
      ST_GET_OP: state_nx_s = enter_p_r ? ST_EXEC   : ST_GET_OP;
      ST_EXEC:   state_nx_s = (alu_done || timeout_s) ? ST_SHOW : ST_EXEC;
      ST_SHOW:   state_nx_s = enter_p_r ? ST_GET_A  : ST_SHOW;
      default:   state_nx_s = ST_GET_A;
    endcase
    if (sw_clr) state_nx_s = ST_GET_A;
    else        state_nx_s = state_nx_s;
  end

  // Output/datapath next values; ALU_DONE takes priority over a simultaneous timeout
  always_comb begin
    a_nx_s   = a_r;
    b_nx_s   = b_r;
    op_nx_s  = op_r;
    y_nx_s   = y_r;
    err_nx_s = err_r;
    go_nx_s  = 1'b0;
    led_nx_s = 4'b0001;
    if (sw_clr) begin
      a_nx_s   = 4'h0;
      b_nx_s   = 4'h0;
      op_nx_s  = 2'b00;
      y_nx_s   = 8'h00;
      err_nx_s = 1'b0;
    end else begin
      case (state_r)
        ST_GET_A:  a_nx_s = enter_p_r ? sw_data : a_r;
        ST_GET_B:  b_nx_s = enter_p_r ? sw_data : b_r;
        ST_GET_OP: begin
          op_nx_s = enter_p_r ? sw_op : op_r;
          go_nx_s = enter_p_r;
        end
        ST_EXEC: begin
          if (alu_done) begin
            y_nx_s = alu_y;
          end else if (timeout_s) begin
            y_nx_s   = 8'hEE;
            err_nx_s = 1'b1;
          end else begin
            y_nx_s = y_r;
          end
        end
        ST_SHOW:   err_nx_s = enter_p_r ? 1'b0 : err_r;
        default:   go_nx_s = 1'b0;
      endcase
    end
    case (state_nx_s)
      ST_GET_A:  led_nx_s = 4'b0001;
      ST_GET_B:  led_nx_s = 4'b0010;
      ST_GET_OP: led_nx_s = 4'b0100;
      ST_EXEC:   led_nx_s = 4'b1000;
      ST_SHOW:   led_nx_s = 4'b1111;
      default:   led_nx_s = 4'b0001;
    endcase
  end

  // Operand/result registers, status outputs and EXEC timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= 4'h0;
      b_r      <= 4'h0;
      op_r     <= 2'b00;
      y_r      <= 8'h00;
      err_r    <= 1'b0;
      go_r     <= 1'b0;
      led_r    <= 4'b0001;
      to_cnt_r <= {TOW{1'b0}};
    end else begin
      a_r      <= a_nx_s;
      b_r      <= b_nx_s;
      op_r     <= op_nx_s;
      y_r      <= y_nx_s;
      err_r    <= err_nx_s;
      go_r     <= go_nx_s;
      led_r    <= led_nx_s;
      to_cnt_r <= (state_r == ST_EXEC && state_nx_s == ST_EXEC) ?
                  to_cnt_r + {{(TOW-1){1'b0}}, 1'b1} : {TOW{1'b0}};
    end
  end

  // Scan next values; digit content follows the post-edge state so DIG_VAL matches DIG_EN
  always_comb begin
    wrap_s   = (pre_r == SCW'(SCAN_DIV - 1));
    pre_nx_s = wrap_s ? {SCW{1'b0}} : pre_r + {{(SCW-1){1'b0}}, 1'b1};
    idx_nx_s = wrap_s ? idx_r + 2'd1 : idx_r;
    case (idx_nx_s)
      2'd0:    dig_val_nx_s = y_nx_s[3:0];
      2'd1:    dig_val_nx_s = y_nx_s[7:4];
      2'd2:    dig_val_nx_s = (state_nx_s == ST_GET_B) ? sw_data : b_nx_s;
      2'd3:    dig_val_nx_s = (state_nx_s == ST_GET_A) ? sw_data : a_nx_s;
      default: dig_val_nx_s = 4'h0;
    endcase
  end

  // Display prescaler, digit index and registered digit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r     <= {SCW{1'b0}};
      idx_r     <= 2'd0;
      dig_en_r  <= 4'b1110;
      dig_val_r <= 4'h0;
    end else begin
      pre_r     <= pre_nx_s;
      idx_r     <= idx_nx_s;
      dig_en_r  <= ~(4'b0001 << idx_nx_s);
      dig_val_r <= dig_val_nx_s;
    end
  end

  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_op    = op_r;
  assign alu_go    = go_r;
  assign err       = err_r;
  assign state_led = led_r;
  assign dig_en    = dig_en_r;
  assign dig_val   = dig_val_r;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level controller for the board's switch-driven 4-bit calculator.
- Debounces the ENTER push switch.
- Sequences operand A, operand B and operation entry from the slide switches.
- Launches the external ALU datapath and waits for its done flag, with a timeout.
- Time-multiplexes the operands and result onto the 4-digit 7-segment display. Segment decode is outside this block.

Parameters:
DB_CYC, 16, consecutive stable cycles required to accept an ENTER level change (min 2)
SCAN_DIV, 1000, clock cycles per display digit slot (min 2)
TO_CYC, 64, maximum cycles spent in EXEC waiting for ALU_DONE (min 2)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset; one clock; asynchronous, active-low
SW_DATA  in  4  operand nibble from slide switches (MSB = leftmost switch)
SW_OP  in  2  operation select from slide switches
SW_ENTER  in  1  raw ENTER push switch, active-high, asynchronous, bouncing
SW_CLR  in  1  synchronous abort/clear, level, active-high
ALU_A  out  4  registered operand A to datapath
ALU_B  out  4  registered operand B to datapath
ALU_OP  out  2  registered operation to datapath
ALU_GO  out  1  one-cycle start pulse to datapath
ALU_Y  in  8  datapath result
ALU_DONE  in  1  datapath result valid (level or pulse)
STATE_LED  out  4  state indicator LEDs
ERR  out  1  timeout flag
DIG_EN  out  4  digit enables, active-low one-cold
DIG_VAL  out  4  hex nibble for the currently enabled digit

Behaviour:
Reset (RST_N low, async):
- state GET_A; A, B, OP and Y registers = 0; ERR = 0; ALU_GO = 0.
- Debouncer and scan counters = 0; DIG_EN = 4'b1110; DIG_VAL = 0; STATE_LED = 4'b0001.

ENTER conditioning:
- 2-FF synchronizer, then debounce counter; the debounced level changes only after DB_CYC consecutive cycles of synchronized input differing from it.
- Any intervening equal sample clears the counter.
- enter_p = one-cycle pulse on the debounced rising edge. A clean raw rise sampled at edge 1 gives enter_p high in the cycle after edge DB_CYC+2.
- Release is debounced identically and produces no pulse.

FSM (all transitions on CLK rising edge):
- GET_A (LED 0001): on enter_p, A<=SW_DATA, go to GET_B.
- GET_B (LED 0010): on enter_p, B<=SW_DATA, go to GET_OP.
- GET_OP (LED 0100): on enter_p, OP<=SW_OP, go to EXEC; ALU_GO=1 for exactly the first EXEC cycle.
- EXEC (LED 1000):
  - Timeout counter cleared on entry; ALU_DONE is sampled from the first EXEC cycle on.
  - On ALU_DONE: Y<=ALU_Y, go to SHOW.
  - If the counter reaches TO_CYC-1 without ALU_DONE: Y<=8'hEE, ERR<=1, go to SHOW.
  - ALU_DONE wins over a simultaneous timeout.
  - enter_p is ignored in EXEC.
- SHOW (LED 1111): on enter_p, go to GET_A and clear ERR. A, B, OP and Y are retained until overwritten.
- SW_CLR high in any state: next state GET_A; A, B, OP and Y cleared; ERR cleared; ALU_GO forced 0. SW_CLR beats a simultaneous enter_p.

Other rules:
- ALU_DONE outside EXEC is ignored.
- ALU_A, ALU_B and ALU_OP are direct register outputs, stable through EXEC.

Display scan:
- The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0.
- DIG_EN = ~(1<<index). DIG_VAL is registered and consistent with DIG_EN in the same cycle.
- Digit 0 = Y[3:0]; digit 1 = Y[7:4].
- Digit 2 = SW_DATA live in GET_B, else B.
- Digit 3 = SW_DATA live in GET_A, else A.

Test Plan:
1. Reset mid-EXEC (assert RST_N low async) -> all outputs immediately at reset values, STATE_LED=0001, DIG_EN=1110.
2. DB_CYC=4; raw ENTER bounces 1-0-1-0 each cycle then holds 1 for 10 cycles -> exactly one enter_p, STATE_LED 0001→0010; a bounce of 3 stable cycles gives none.
3. Enter A=4'h9, B=4'h6, OP=2'b01; datapath returns ALU_DONE with ALU_Y=8'h0F three cycles after ALU_GO -> ALU_GO one cycle wide, ALU_A=9, ALU_B=6, ALU_OP=1, SHOW with digits 3..0 = 9,6,0,F, ERR=0.
4. TO_CYC=8, ALU_DONE held low -> SHOW exactly 8 cycles after EXEC entry, Y=8'hEE, ERR=1; next enter_p -> GET_A, ERR=0.
5. In GET_B, pulse enter_p and SW_CLR in the same cycle -> GET_A, A=B=OP=Y=0, no ALU_GO.
6. SCAN_DIV=3 over 12 cycles -> DIG_EN sequence 1110,1101,1011,0111, each held 3 cycles, wraps to 1110; in GET_A, toggling SW_DATA changes digit 3 live.
